sort_scheduler: RTL and testbench
=================================

# sort_scheduler

Round-robin scheduler that shares one `bubble_sort` engine (N 8-bit keys, active-high `rst`, one-cycle `start`, sticky `done`) among NREQ requesters. It accepts one job at a time from a requester and latches that job's keys. It then launches the engine, waits for `done` under a timeout, and returns the sorted keys with the requester ID over a valid/ready response. It also pulses the engine reset after every job, because the engine only leaves its DONE state on reset.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `N`, default 8: keys per job; must equal the engine's N.
- `TIMEOUT`, default 256: maximum WAIT cycles before a job is aborted; must be at least 1.
- `clk` in, 1: system clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `req_valid` in, NREQ: bit r means requester r has a job pending.
- `req_data` in, NREQ*N*8: keys for requester r at bits [r*N*8 +: N*8]; key k at [+k*8 +: 8].
- `req_ready` out, NREQ: one-hot acceptance pulse, one cycle.
- `resp_valid` out, 1: result available.
- `resp_ready` in, 1: consumer accepts the result.
- `resp_id` out, $clog2(NREQ): requester that owns the result.
- `resp_data` out, N*8: sorted keys in the same packing as `req_data`.
- `resp_err` out, 1: job timed out; `resp_data` is all zero.
- `busy` out, 1: high in every state except IDLE.
- `job_count` out, 16: completed jobs, saturating at 0xFFFF.
- `eng_rst` out, 1: engine reset, active-high.
- `eng_start` out, 1: engine start pulse.
- `eng_data_in` out, N*8: keys to the engine.
- `eng_data_out` in, N*8: engine result.
- `eng_done` in, 1: engine completion.

## Operation
- **State machine:** IDLE, LAUNCH, WAIT, RESP, CLEAR.
- **IDLE:**
  - If any `req_valid` bit is set, the winner is the first set bit searching upward from `last_grant+1`, wrapping modulo NREQ.
  - Assert `req_ready[winner]` for that cycle only.
  - Latch the winner's keys into the job buffer, which drives `eng_data_in`.
  - Set `last_grant` = winner and `cur_id` = winner, then go to LAUNCH.
- **LAUNCH:** `eng_start`=1 for exactly one cycle; clear the WAIT counter; go to WAIT.
- **WAIT:**
  - Counter increments each cycle.
  - If `eng_done`=1, latch `eng_data_out` into the result buffer, set `resp_err`=0, and go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1, clear the result buffer to 0, set `resp_err`=1, and go to RESP.
  - If `eng_done` arrives in the same cycle the counter reaches TIMEOUT-1, `eng_done` wins.
- **RESP:**
  - Hold `resp_valid`=1; keep `resp_id`, `resp_data` and `resp_err` stable.
  - On `resp_ready`=1, go to CLEAR and increment `job_count` (saturating) only if `resp_err`=0.
- **CLEAR:** `eng_rst`=1 for one cycle, then IDLE.
- **Request handling:**
  - Requests arriving while `busy` are not accepted.
  - `req_valid` may drop at any time before the `req_ready` pulse without effect.
- **Round-robin fairness:** with all NREQ requesters continuously valid, grants cycle 0,1,2,…,NREQ-1,0,…

## Timing
- **Reset (`rst_n`=0):**
  - State is IDLE.
  - `last_grant` = NREQ-1, so requester 0 has first priority.
  - `eng_rst`=1, so the engine is held in reset.
  - All other outputs are 0, including job/result buffers, counter and `job_count`.
  - `eng_rst` deasserts on the first clock edge after `rst_n` rises.
  - Reset asserted mid-job aborts the job with no response and reasserts `eng_rst`.
- **Latency from accept to `resp_valid`:**
  - Accept cycle in IDLE (edge t), LAUNCH at t+1, engine samples `start` at the edge ending LAUNCH.
  - WAIT runs until `eng_done` is sampled high; `resp_valid` rises the cycle after.
  - With the N=8 engine, `done` is high about 38 cycles after start.
- **Job spacing:** minimum 4 cycles between `req_ready` pulses plus engine time. The sequence is accept, LAUNCH, ≥1 WAIT, ≥1 RESP, CLEAR.
- **Engine reset ordering:** `eng_rst` is asserted for the whole CLEAR cycle, so `eng_done` is 0 when the next LAUNCH occurs.
- **Registered outputs:** all outputs are registered. `eng_data_in` changes only in the accept cycle.

## Test plan
- **Single job:** after reset, requester 2 sends keys {5,3,9,1,7,0,255,4} (key0 first) with `resp_ready`=1. Expect `req_ready`=0b0100 for one cycle, one `eng_start` pulse, `resp_id`=2, `resp_data`={0,1,3,4,5,7,9,255}, `resp_err`=0, one `eng_rst` pulse, `job_count`=1.
- **Round-robin:** all 4 requesters held valid for 8 jobs. Expect grant order 0,1,2,3,0,1,2,3 and `job_count`=8.
- **Backpressure:** `resp_ready`=0 for 20 cycles after `resp_valid` rises. Expect `resp_valid`/`resp_id`/`resp_data` stable, no new `req_ready`, and `eng_rst` only after `resp_ready` goes to 1.
- **Timeout:** TIMEOUT=16 with the engine stubbed so `done` never rises. Expect `resp_valid` 17 cycles after the accept cycle (accept + LAUNCH + 16 WAIT cycles, high the following cycle), `resp_err`=1, `resp_data`=0, `job_count` unchanged, then `eng_rst` pulse.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT. Expect all outputs 0 and `eng_rst`=1 asynchronously. After release, the next grant goes to requester 0 and sorts correctly.
- **Already-sorted and duplicate keys:** input {7,7,7,7,7,7,7,7} expects an identical output; input {0,…,7} expects an identical output with `resp_err`=0.

Source files
------------

// File: rtl/sort_scheduler_if.sv
// Request/response buses between the requesters, the result consumer and sort_scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface sort_scheduler_if #(
  parameter int NREQ = 4,
  parameter int N    = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*N*8-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [N*8-1:0]      resp_data;
  logic                resp_err;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/sort_scheduler.sv
// Round-robin scheduler sharing one bubble_sort engine among NREQ requesters,
// with a WAIT timeout and an engine reset pulse after every job.
//
// state    | meaning
// S_IDLE   | arbitrate, accept one job, latch its keys
// S_LAUNCH | eng_start high for this cycle, clear WAIT counter
// S_WAIT   | wait for eng_done or timeout
// S_RESP   | hold the response until resp_ready
// S_CLEAR  | eng_rst high for this cycle
module sort_scheduler #(
  parameter int NREQ    = 4,
  parameter int N       = 8,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  sort_scheduler_if.slave    bus,
  output logic               busy_o,
  output logic [15:0]        job_count_o,
  output logic               eng_rst_o,
  output logic               eng_start_o,
  output logic [N*8-1:0]     eng_data_in_o,
  input  logic [N*8-1:0]     eng_data_out_i,
  input  logic               eng_done_i
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP, S_CLEAR} state_t;

  state_t            state_q;
  logic [IDW-1:0]    last_grant_q;
  logic [IDW-1:0]    cur_id_q;
  logic [CW-1:0]     wait_cnt_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [N*8-1:0]    job_q;
  logic [N*8-1:0]    result_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              busy_q;
  logic              eng_rst_q;
  logic              eng_start_q;
  logic [15:0]       job_count_q;

  logic              found_d;
  logic [IDW-1:0]    winner_d;
  logic [NREQ-1:0]   grant_oh_d;
  logic [N*8-1:0]    win_keys_d;
  int                idx_c;

  // First pending requester searching upward from last_grant+1, wrapping.
  always_comb begin
    found_d    = 1'b0;
    winner_d   = '0;
    grant_oh_d = '0;
    win_keys_d = '0;
    idx_c      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_c = (int'(last_grant_q) + i) % NREQ;
      if (!found_d && bus.req_valid[idx_c]) begin
        found_d           = 1'b1;
        winner_d          = IDW'(idx_c);
        grant_oh_d[idx_c] = 1'b1;
        win_keys_d        = bus.req_data[idx_c*N*8 +: N*8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NREQ-1);
      cur_id_q     <= '0;
      wait_cnt_q   <= '0;
      req_ready_q  <= '0;
      job_q        <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      eng_rst_q    <= 1'b1;
      eng_start_q  <= 1'b0;
      job_count_q  <= '0;
    end else begin
      req_ready_q <= '0;
      eng_start_q <= 1'b0;
      eng_rst_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            req_ready_q  <= grant_oh_d;
            job_q        <= win_keys_d;
            last_grant_q <= winner_d;
            cur_id_q     <= winner_d;
            eng_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last counted cycle still wins over the timeout.
          if (eng_done_i) begin
            result_q     <= eng_data_out_i;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (wait_cnt_q == CW'(TIMEOUT-1)) begin
            result_q     <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            eng_rst_q    <= 1'b1;
            if (!resp_err_q && job_count_q != 16'hFFFF) begin
              job_count_q <= job_count_q + 16'd1;
            end
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = cur_id_q;
  assign bus.resp_data  = result_q;
  assign bus.resp_err   = resp_err_q;
  assign busy_o         = busy_q;
  assign job_count_o    = job_count_q;
  assign eng_rst_o      = eng_rst_q;
  assign eng_start_o    = eng_start_q;
  assign eng_data_in_o  = job_q;
endmodule

// File: tb/tb_sort_scheduler.sv
// Bench for sort_scheduler: a behavioural sort engine stub with programmable done
// delay, a round-robin/sorting reference model, and directed plus random jobs.
module tb_sort_scheduler;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] job_count;
  logic        eng_rst;
  logic        eng_start;
  logic [63:0] eng_data_in;
  logic [63:0] eng_data_out = '0;
  logic        eng_done = 1'b0;

  sort_scheduler_if #(.NREQ(4), .N(8)) bus ();

  sort_scheduler #(.NREQ(4), .N(8), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy_o        (busy),
    .job_count_o   (job_count),
    .eng_rst_o     (eng_rst),
    .eng_start_o   (eng_start),
    .eng_data_in_o (eng_data_in),
    .eng_data_out_i(eng_data_out),
    .eng_done_i    (eng_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0, rst_cnt = 0, grant_cnt = 0;
  int eng_delay = 0;
  int stub_cnt = 0;
  logic [63:0] stub_keys = '0;
  logic [63:0] req_keys [4];
  int last_m = 3;
  logic [15:0] job_m = '0;

  // Ascending order by counting each key value; key0 ends up in the low byte.
  function automatic logic [63:0] sort_ref(input logic [63:0] k);
    logic [63:0] r;
    int pos;
    r = '0;
    pos = 0;
    for (int v = 0; v < 256; v++)
      for (int j = 0; j < 8; j++)
        if (k[j*8 +: 8] == 8'(v)) begin
          r[pos*8 +: 8] = k[j*8 +: 8];
          pos++;
        end
    return r;
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int last);
    for (int i = 1; i <= 4; i++)
      if (m[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  // Engine stand-in: sticky done eng_delay cycles after start; eng_delay==0 never finishes.
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_done <= 1'b0;
      stub_cnt <= 0;
    end else if (eng_start) begin
      stub_keys <= eng_data_in;
      stub_cnt  <= eng_delay;
    end else if (stub_cnt > 0) begin
      if (stub_cnt == 1) begin
        eng_done     <= 1'b1;
        eng_data_out <= sort_ref(stub_keys);
      end
      stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (eng_start) start_cnt++;
      if (eng_rst) rst_cnt++;
      if (bus.req_ready != '0) grant_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    bus.req_data = {req_keys[3], req_keys[2], req_keys[1], req_keys[0]};
  endtask

  task automatic do_job(input string tag, input int exp_id, input int delay,
                        input logic [63:0] ok_data, input int hold, input bit drop);
    bit seen, stable, exp_err;
    int lat, s0, r0, g0, exp_lat;
    logic [63:0] exp_data, d_snap;
    logic [1:0] id_snap;
    eng_delay = delay;
    exp_err  = (delay < 1) || (delay > TO-1);
    exp_data = exp_err ? 64'd0 : ok_data;
    exp_lat  = exp_err ? TO + 1 : delay + 2;
    bus.resp_ready = (hold == 0);
    s0 = start_cnt; r0 = rst_cnt; g0 = grant_cnt;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.req_ready != '0);
    end
    check({tag, "_grant"}, 64'(bus.req_ready), 64'(1) << exp_id);
    check({tag, "_eng_in"}, eng_data_in, req_keys[exp_id]);
    if (drop) bus.req_valid[exp_id] = 1'b0;
    @(negedge clk);
    check({tag, "_ready_pulse"}, 64'(bus.req_ready), 64'd0);
    lat = 1;
    seen = bus.resp_valid;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      seen = bus.resp_valid;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_id"}, 64'(bus.resp_id), 64'(exp_id));
    check({tag, "_data"}, bus.resp_data, exp_data);
    check({tag, "_err"}, 64'(bus.resp_err), 64'(exp_err));
    d_snap = bus.resp_data;
    id_snap = bus.resp_id;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_data !== d_snap || bus.resp_id !== id_snap ||
          bus.resp_err !== exp_err) stable = 1'b0;
    end
    if (hold > 0) begin
      check({tag, "_hold_stable"}, 64'(stable), 64'd1);
      check({tag, "_hold_no_rst"}, 64'(rst_cnt - r0), 64'd0);
      check({tag, "_hold_no_grant"}, 64'(grant_cnt - g0), 64'd1);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_clear"}, 64'({eng_rst, bus.resp_valid, busy}), 64'(3'b101));
    @(negedge clk);
    check({tag, "_idle"}, 64'({eng_rst, busy}), 64'd0);
    if (!exp_err && job_m != 16'hFFFF) job_m++;
    last_m = exp_id;
    check({tag, "_job_count"}, 64'(job_count), 64'(job_m));
    check({tag, "_starts"}, 64'(start_cnt - s0), 64'd1);
    check({tag, "_rsts"}, 64'(rst_cnt - r0), 64'd1);
    check({tag, "_grants"}, 64'(grant_cnt - g0), 64'd1);
  endtask

  initial begin
    bit seen;
    logic [3:0] m;
    int w;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.resp_ready = 1'b1;
    for (int r = 0; r < 4; r++) req_keys[r] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.resp_err, busy, eng_start, eng_rst}),
          64'(9'b000000001));
    check("rst_data", bus.resp_data | eng_data_in, 64'd0);
    check("rst_count_id", 64'({job_count, bus.resp_id}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_eng_rst", 64'(eng_rst), 64'd0);
    repeat (2) @(negedge clk);

    // Single job from requester 2
    req_keys[2] = {8'd4, 8'd255, 8'd0, 8'd7, 8'd1, 8'd9, 8'd3, 8'd5};
    drive_data();
    bus.req_valid = 4'b0100;
    do_job("single", 2, 10, {8'd255, 8'd9, 8'd7, 8'd5, 8'd4, 8'd3, 8'd1, 8'd0}, 0, 1'b1);

    // Duplicates and already-sorted input come back unchanged
    req_keys[0] = {8{8'd7}};
    drive_data();
    bus.req_valid = 4'b0001;
    do_job("dup", 0, 5, {8{8'd7}}, 0, 1'b1);
    req_keys[1] = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    drive_data();
    bus.req_valid = 4'b0010;
    do_job("sorted", 1, 3, {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 0, 1'b1);

    // Backpressure with other requesters pending
    req_keys[3] = {$urandom, $urandom};
    drive_data();
    bus.req_valid = 4'b1011;
    do_job("backpressure", rr_pick(4'b1011, last_m), 7, sort_ref(req_keys[3]), 20, 1'b1);

    // Timeout and the done/timeout boundary
    bus.req_valid = 4'b0001;
    do_job("timeout", 0, 0, 64'd0, 0, 1'b1);
    req_keys[1] = {$urandom, $urandom};
    drive_data();
    bus.req_valid = 4'b0010;
    do_job("done_last", 1, TO - 1, sort_ref(req_keys[1]), 0, 1'b1);
    req_keys[2] = {$urandom, $urandom};
    drive_data();
    bus.req_valid = 4'b0100;
    do_job("done_late", 2, TO, sort_ref(req_keys[2]), 0, 1'b1);

    // Reset in the middle of WAIT
    eng_delay = 0;
    bus.req_valid = 4'b1000;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (bus.req_ready != '0);
    end
    check("rstmid_grant", 64'(bus.req_ready), 64'(4'b1000));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_ctrl", 64'({bus.req_ready, bus.resp_valid, bus.resp_err, busy, eng_start, eng_rst}),
          64'(9'b000000001));
    check("rstmid_data", bus.resp_data | eng_data_in, 64'd0);
    check("rstmid_count_id", 64'({job_count, bus.resp_id}), 64'd0);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_release", 64'({eng_rst, busy, bus.resp_valid}), 64'd0);
    last_m = 3;
    job_m = '0;

    // Round-robin with all requesters continuously valid
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      for (int r = 0; r < 4; r++) req_keys[r] = {$urandom, $urandom};
      drive_data();
      do_job("rr", j % 4, $urandom_range(1, TO - 1), sort_ref(req_keys[j % 4]), 0, 1'b0);
    end
    check("rr_job_count", 64'(job_count), 64'd8);

    // Random masks, keys, engine delays and backpressure
    for (int j = 0; j < 24; j++) begin
      m = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++) req_keys[r] = {$urandom, $urandom};
      drive_data();
      bus.req_valid = m;
      w = rr_pick(m, last_m);
      do_job("rand", w, $urandom_range(0, TO + 1), sort_ref(req_keys[w]),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
